// File: rtl/demux_pkg.sv
// Shared types and helpers for the packet demux router.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam int CNT_W = 16;

  // Destination index width; a 1:2 demux still needs one select bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_out_reg.sv
// Single-entry valid/ready pipeline register holding {data, last, dest}.
module demux_out_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic [SEL_W-1:0]  i_dest,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic [SEL_W-1:0]  o_dest
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [SEL_W-1:0]  r_dest;

  // Payload only changes on load, so it holds stable while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_dest  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
      r_dest  <= i_dest;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_dest  = r_dest;

endmodule

// File: rtl/demux_pkt_router.sv
// Packet router for a 1:N demux: per-packet destination latch, drop of bad destinations.
// Optional per-sink/drop counters are enabled by defining DEMUX_STATS_EN.
module demux_pkt_router
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 2,
  parameter int SEL_W  = sel_w(N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [SEL_W-1:0]  s_dest,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              err_dest
`ifdef DEMUX_STATS_EN
  ,
  output logic [N_OUT*CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  input  logic                   stats_clr
`endif
);

  localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

  state_t            r_state, w_next;
  logic [SEL_W-1:0]  r_cur_dest, w_cur_dest_next, w_ld_dest;
  logic              r_err, w_err, w_load;
  logic              w_reg_valid, w_reg_last;
  logic [DATA_W-1:0] w_reg_data;
  logic [SEL_W-1:0]  w_reg_dest;
  logic              w_sel_ready, w_drain, w_accept, w_dest_ok;

  demux_out_reg #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_ready (w_sel_ready),
    .i_data  (s_data),
    .i_last  (s_last),
    .i_dest  (w_ld_dest),
    .o_valid (w_reg_valid),
    .o_data  (w_reg_data),
    .o_last  (w_reg_last),
    .o_dest  (w_reg_dest)
  );

  // Only the sink addressed by the held beat can drain it; others are ignored.
  always_comb begin
    w_sel_ready = 1'b0;
    m_valid     = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (w_reg_dest == SEL_W'(i)) begin
        w_sel_ready = m_ready[i];
        m_valid[i]  = w_reg_valid;
      end
    end
  end

  assign w_drain   = w_reg_valid && w_sel_ready;
  assign s_ready   = (r_state == DROP) ? 1'b1 : (!w_reg_valid || w_sel_ready);
  assign w_accept  = s_valid && s_ready;
  assign w_dest_ok = ({1'b0, s_dest} < N_OUT_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cur_dest <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cur_dest <= w_cur_dest_next;
      r_err      <= w_err;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_cur_dest_next = r_cur_dest;
    w_ld_dest       = r_cur_dest;
    w_load          = 1'b0;
    w_err           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_dest_ok) begin
            w_load          = 1'b1;
            w_ld_dest       = s_dest;
            w_cur_dest_next = s_dest;
            w_next          = s_last ? IDLE : ROUTE;
          end else begin
            w_err  = 1'b1;
            w_next = s_last ? IDLE : DROP;
          end
        end
      end
      ROUTE: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (s_last) w_next = IDLE;
        end
      end
      DROP: begin
        if (w_accept && s_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign m_data   = w_reg_data;
  assign m_last   = w_reg_last;
  assign busy     = (r_state != IDLE);
  assign err_dest = r_err;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_pkt_cnt [N_OUT];
  logic [CNT_W-1:0] r_drop_cnt;

  // A packet counts when its last beat leaves the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
      for (int i = 0; i < N_OUT; i++) r_pkt_cnt[i] <= '0;
    end else if (stats_clr) begin
      r_drop_cnt <= '0;
      for (int i = 0; i < N_OUT; i++) r_pkt_cnt[i] <= '0;
    end else begin
      if (w_err) r_drop_cnt <= r_drop_cnt + 1'b1;
      for (int i = 0; i < N_OUT; i++) begin
        if (w_drain && w_reg_last && (w_reg_dest == SEL_W'(i)))
          r_pkt_cnt[i] <= r_pkt_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_pkt_cnt
    assign pkt_cnt[g*CNT_W +: CNT_W] = r_pkt_cnt[g];
  end
  assign drop_cnt = r_drop_cnt;
`endif

endmodule
